// File: rtl/mem_responder.sv
// Word-addressed 32-bit memory responder with a request-edge handshake (Done/Busy/Error).
// Optional wait states between request and access: define MEM_WAIT_STATES_EN.
module mem_responder #(
    parameter int ADDR_W      = 9,
    parameter int WAIT_CYCLES = 2
) (
    input  logic        Clock,
    input  logic        Resetn,
    input  logic        Read,
    input  logic        Write,
    input  logic [31:0] Address,
    input  logic [31:0] Datain,
    output logic [31:0] Mdatain,
    output logic        Done,
    output logic        Busy,
    output logic        Error
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
`ifdef MEM_WAIT_STATES_EN
        ST_WAIT   = 2'd1,
`endif
        ST_ACCESS = 2'd2,
        ST_DONE   = 2'd3
    } state_t;

    state_t state, state_next;

    logic              rd_q, rd_qq, wr_q, wr_qq;
    logic              rd_rise, wr_rise;
    logic              req_valid, req_illegal;
    logic [ADDR_W-1:0] addr_r;
    logic [31:0]       data_r;
    logic              op_wr;
    logic [31:0]       mem [2**ADDR_W];
`ifdef MEM_WAIT_STATES_EN
    logic [3:0]        wait_cnt;
`endif

    logic unused_bits;
    assign unused_bits = ^{Address[31:ADDR_W], WAIT_CYCLES[0]};

    // A rise counts as a request only if the other line is low in the same registered sample.
    assign rd_rise     = rd_q & ~rd_qq;
    assign wr_rise     = wr_q & ~wr_qq;
    assign req_valid   = (rd_rise & ~wr_q) | (wr_rise & ~rd_q);
    assign req_illegal = (rd_rise & wr_q) | (wr_rise & rd_q);

    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: begin
                if (req_valid) begin
`ifdef MEM_WAIT_STATES_EN
                    state_next = ST_WAIT;
`else
                    state_next = ST_ACCESS;
`endif
                end
            end
`ifdef MEM_WAIT_STATES_EN
            ST_WAIT: begin
                if (wait_cnt == 4'd0) begin
                    state_next = ST_ACCESS;
                end
            end
`endif
            ST_ACCESS: state_next = ST_DONE;
            ST_DONE:   state_next = ST_IDLE;
            default:   state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        Busy  = (state != ST_IDLE);
        Done  = (state == ST_DONE);
        Error = (state == ST_IDLE) && req_illegal;
    end

    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            rd_q    <= 1'b0;
            rd_qq   <= 1'b0;
            wr_q    <= 1'b0;
            wr_qq   <= 1'b0;
            addr_r  <= '0;
            data_r  <= '0;
            op_wr   <= 1'b0;
            Mdatain <= '0;
        end else begin
            rd_q  <= Read;
            rd_qq <= rd_q;
            wr_q  <= Write;
            wr_qq <= wr_q;
            if (state == ST_IDLE && req_valid) begin
                addr_r <= Address[ADDR_W-1:0];
                data_r <= Datain;
                op_wr  <= wr_rise;
            end
            if (state == ST_ACCESS && !op_wr) begin
                Mdatain <= mem[addr_r];
            end
        end
    end

`ifdef MEM_WAIT_STATES_EN
    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            wait_cnt <= '0;
        end else if (state == ST_IDLE && req_valid) begin
            wait_cnt <= 4'(WAIT_CYCLES - 1);
        end else if (state == ST_WAIT && wait_cnt != 4'd0) begin
            wait_cnt <= wait_cnt - 4'd1;
        end
    end
`endif

    // Memory has no reset so contents survive Resetn; writes only happen from ACCESS.
    always_ff @(posedge Clock) begin
        if (state == ST_ACCESS && op_wr) begin
            mem[addr_r] <= data_r;
        end
    end

endmodule

// File: tb/tb_mem_responder.sv
// Self-checking bench for mem_responder: table-driven accesses with a read-data scoreboard,
// plus hand sequences for illegal requests, ignored re-requests and reset abort.
module tb_mem_responder;

    localparam int ADDR_W      = 9;
    localparam int WAIT_CYCLES = 2;
`ifdef MEM_WAIT_STATES_EN
    localparam int LAT = 2 + WAIT_CYCLES;
`else
    localparam int LAT = 2;
`endif

    logic        Clock = 1'b0;
    logic        Resetn;
    logic        Read;
    logic        Write;
    logic [31:0] Address;
    logic [31:0] Datain;
    logic [31:0] Mdatain;
    logic        Done;
    logic        Busy;
    logic        Error;

    mem_responder #(.ADDR_W(ADDR_W), .WAIT_CYCLES(WAIT_CYCLES)) dut (
        .Clock   (Clock),
        .Resetn  (Resetn),
        .Read    (Read),
        .Write   (Write),
        .Address (Address),
        .Datain  (Datain),
        .Mdatain (Mdatain),
        .Done    (Done),
        .Busy    (Busy),
        .Error   (Error)
    );

    always #5 Clock = ~Clock;

    typedef struct {
        bit          wr;
        logic [31:0] addr;
        logic [31:0] data;
        logic [31:0] exp_rd;
    } vec_t;

    int          tests = 0;
    int          fails = 0;
    logic [31:0] exp_q [$];
    logic [31:0] last_rd;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Issue one legal access, measure latency to Done, and check Busy/Done/Mdatain behaviour.
    task automatic do_access(input bit wr, input logic [31:0] addr,
                             input logic [31:0] data, input logic [31:0] exp_rd);
        int          lat;
        logic [31:0] exp;
        @(posedge Clock); #1;
        Address = addr;
        Datain  = data;
        if (wr) Write = 1'b1;
        else begin
            Read = 1'b1;
            exp_q.push_back(exp_rd);
        end
        @(posedge Clock);
        lat = -1;
        for (int i = 0; i <= 40; i++) begin
            @(negedge Clock);
            if (i == 0) check("idle_at_sample", {31'd0, Busy}, 32'd0);
            if (i == 1) check("busy_after_req", {31'd0, Busy}, 32'd1);
            if (Done) begin
                lat = i;
                break;
            end
            check("no_error_legal", {31'd0, Error}, 32'd0);
            @(posedge Clock);
        end
        check("done_latency", 32'(lat), 32'(LAT));
        if (!wr) begin
            exp = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hXXXX_XXXX;
            check("read_data", Mdatain, exp);
            last_rd = exp;
        end else begin
            check("mdatain_hold_on_write", Mdatain, last_rd);
        end
        Read  = 1'b0;
        Write = 1'b0;
        @(posedge Clock);
        @(negedge Clock);
        check("done_one_cycle", {31'd0, Done}, 32'd0);
        check("idle_after_done", {31'd0, Busy}, 32'd0);
    endtask

    initial begin
        vec_t vecs [13];
        int   dones;
        int   errs;

        vecs[0]  = '{1'b1, 32'h0000_0007, 32'h4A92_0000, 32'h0};
        vecs[1]  = '{1'b0, 32'h0000_0007, 32'h0,         32'h4A92_0000};
        vecs[2]  = '{1'b1, 32'h0000_0010, 32'h0000_0024, 32'h0};
        vecs[3]  = '{1'b1, 32'h0000_0005, 32'h0000_0026, 32'h0};
        vecs[4]  = '{1'b0, 32'h0000_0005, 32'h0,         32'h0000_0026};
        vecs[5]  = '{1'b1, 32'h0000_03FF, 32'hDEAD_BEEF, 32'h0};
        vecs[6]  = '{1'b0, 32'h0000_01FF, 32'h0,         32'hDEAD_BEEF};
        vecs[7]  = '{1'b1, 32'h0000_0100, 32'h1234_5678, 32'h0};
        vecs[8]  = '{1'b0, 32'h0000_0100, 32'h0,         32'h1234_5678};
        vecs[9]  = '{1'b0, 32'h0000_0010, 32'h0,         32'h0000_0024};
        vecs[10] = '{1'b1, 32'h0000_01FF, 32'hCAFE_F00D, 32'h0};
        vecs[11] = '{1'b0, 32'h0000_03FF, 32'h0,         32'hCAFE_F00D};
        vecs[12] = '{1'b0, 32'hFFFF_FE07, 32'h0,         32'h4A92_0000};

        Resetn  = 1'b0;
        Read    = 1'b0;
        Write   = 1'b0;
        Address = '0;
        Datain  = '0;
        last_rd = '0;
        repeat (3) @(posedge Clock);
        @(negedge Clock);
        check("reset_mdatain", Mdatain, 32'd0);
        check("reset_done", {31'd0, Done}, 32'd0);
        check("reset_busy", {31'd0, Busy}, 32'd0);
        check("reset_error", {31'd0, Error}, 32'd0);
        @(posedge Clock); #1;
        Resetn = 1'b1;

        for (int i = 0; i < 13; i++) begin
            do_access(vecs[i].wr, vecs[i].addr, vecs[i].data, vecs[i].exp_rd);
        end

        // Read and Write rising together: Error pulse, no access.
        @(posedge Clock); #1;
        Address = 32'h0000_0010;
        Datain  = 32'h0000_0BAD;
        Read    = 1'b1;
        Write   = 1'b1;
        @(posedge Clock);
        @(negedge Clock);
        check("both_rise_error", {31'd0, Error}, 32'd1);
        check("both_rise_busy", {31'd0, Busy}, 32'd0);
        @(posedge Clock);
        @(negedge Clock);
        check("both_rise_error_end", {31'd0, Error}, 32'd0);
        check("both_rise_still_idle", {31'd0, Busy}, 32'd0);
        Read  = 1'b0;
        Write = 1'b0;
        do_access(1'b0, 32'h0000_0010, 32'h0, 32'h0000_0024);

        // Read rises, falls and rises again while busy: one Done only.
        @(posedge Clock); #1;
        Address = 32'h0000_0005;
        Read    = 1'b1;
        @(posedge Clock); #1;
        Read = 1'b0;
        @(posedge Clock); #1;
        Read = 1'b1;
        dones = 0;
        errs  = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge Clock);
            if (Done) dones++;
            if (Error) errs++;
        end
        check("rerequest_done_count", 32'(dones), 32'd1);
        check("rerequest_no_error", 32'(errs), 32'd0);
        check("rerequest_read_data", Mdatain, 32'h0000_0026);
        last_rd = 32'h0000_0026;

        // Write rising while Read is still held high in IDLE: Error, memory untouched.
        Address = 32'h0000_0010;
        Datain  = 32'h0000_0077;
        Write   = 1'b1;
        @(posedge Clock);
        @(negedge Clock);
        check("held_read_write_error", {31'd0, Error}, 32'd1);
        check("held_read_write_idle", {31'd0, Busy}, 32'd0);
        @(posedge Clock);
        @(negedge Clock);
        check("held_read_write_error_end", {31'd0, Error}, 32'd0);
        Read  = 1'b0;
        Write = 1'b0;
        do_access(1'b0, 32'h0000_0010, 32'h0, 32'h0000_0024);

        // Reset before the ACCESS edge of a write aborts it.
        @(posedge Clock); #1;
        Address = 32'h0000_0010;
        Datain  = 32'h0000_0022;
        Write   = 1'b1;
        @(posedge Clock);
        @(posedge Clock); #1;
        Resetn = 1'b0;
        Write  = 1'b0;
        @(negedge Clock);
        check("abort_mdatain", Mdatain, 32'd0);
        check("abort_done", {31'd0, Done}, 32'd0);
        check("abort_busy", {31'd0, Busy}, 32'd0);
        check("abort_error", {31'd0, Error}, 32'd0);
        @(posedge Clock); #1;
        Resetn  = 1'b1;
        last_rd = '0;
        do_access(1'b0, 32'h0000_0010, 32'h0, 32'h0000_0024);

        check("scoreboard_empty", 32'(exp_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/mem_responder.md
MEM_RESPONDER -- requirements
Module: mem_responder

Interface
REQ-001 Parameter ADDR_W, default 9, SHALL set word-address width; depth is 2**ADDR_W words of 32 bits.
REQ-002 Parameter WAIT_CYCLES, default 2, SHALL set inserted wait cycles; used only when MEM_WAIT_STATES_EN is defined; legal range 1..15.
REQ-003 Clock  input  1  SHALL be the single clock; all state updates occur on its rising edge.
REQ-004 Resetn  input  1  SHALL be the reset: asynchronous, active-low.
REQ-005 Read  input  1  SHALL be the read request level from the datapath control.
REQ-006 Write  input  1  SHALL be the write request level from the datapath control.
REQ-007 Address  input  32  SHALL carry MAR contents; only bits [ADDR_W-1:0] are used.
REQ-008 Datain  input  32  SHALL carry MDR contents as write data.
REQ-009 Mdatain  output  32  SHALL carry read data to the MDR input mux.
REQ-010 Done  output  1  SHALL pulse high for exactly one cycle when an access completes.
REQ-011 Busy  output  1  SHALL be high whenever the FSM is not IDLE.
REQ-012 Error  output  1  SHALL pulse high for one cycle on an illegal request.

Function
REQ-013 Request edges: Read and Write SHALL be registered each cycle; a request is a 0->1 transition of exactly one of them, sampled while in IDLE.
REQ-014 FSM states: IDLE, WAIT, ACCESS, DONE.
REQ-015 IDLE: on a valid request edge, Address bits, Datain and the operation SHALL be latched. Next state is WAIT if the macro is defined, else ACCESS.
REQ-016 WAIT: a down-counter loaded with WAIT_CYCLES-1 SHALL decrement each cycle. The FSM leaves for ACCESS when the counter is 0.
REQ-017 ACCESS: a write SHALL store the latched data at the latched address; a read SHALL load Mdatain with that address's contents. Next state is DONE.
REQ-018 DONE: Done is high for this one cycle; next state is IDLE.
REQ-019 Latency without the macro: request sampled at edge N; Done and read data valid from edge N+2 until edge N+3.
REQ-020 Mdatain SHALL hold its value until the next read completes; writes SHALL NOT change Mdatain.
REQ-021 Requests rising while Busy is high SHALL be ignored: not queued, and they produce no Error.
REQ-022 Read and Write rising together, or one rising while the other is already high, in IDLE: Error SHALL go high for one cycle. The FSM stays IDLE and memory is unchanged.
REQ-023 Address aliasing: upper Address bits SHALL be ignored, so 0x3FF maps to word 0x1FF when ADDR_W=9.
REQ-024 A write followed immediately by a read of the same address SHALL return the newly written data.

Reset
REQ-025 While Resetn is low: state=IDLE, Mdatain=0, Done=0, Busy=0, Error=0, edge registers=0, wait counter=0.
REQ-026 Memory contents SHALL NOT be cleared by reset.
REQ-027 Reset asserted before the ACCESS edge of a write SHALL abort it; the memory word is unmodified.

Configuration
REQ-028 MEM_WAIT_STATES_EN defined: the WAIT state is present, and latency from the request-sampling edge N to Done is N+2+WAIT_CYCLES.
REQ-029 MEM_WAIT_STATES_EN undefined: the WAIT state and counter are not compiled in, and latency is per REQ-019.

Verification
REQ-030 No macro: write 0x4A920000 to address 0x007, then read 0x007. Mdatain=0x4A920000, Done high exactly one cycle at edge N+2, Busy high edges N+1..N+2.
REQ-031 Read and Write rise on the same edge at address 0x010 holding 0x00000024. Error is high one cycle, Busy stays 0, and a later read of 0x010 returns 0x00000024.
REQ-032 Read rises, falls, and rises again while Busy. Exactly one Done; the second rise is ignored.
REQ-033 Resetn pulsed low during ACCESS-pending write of 0x00000022 to 0x010 (old value 0x00000024). All outputs are 0; a subsequent read returns 0x00000024.
REQ-034 MEM_WAIT_STATES_EN, WAIT_CYCLES=2, read of 0x005 holding 0x00000026. Done at edge N+4, Mdatain=0x00000026.
REQ-035 Write 0xDEADBEEF to Address 0x000003FF, then read Address 0x000001FF. Mdatain=0xDEADBEEF.
